sram_arbiter: RTL

//  Shares the single off-chip SRAM between the CPU data port and the VGA line-buffer fetcher.

---
 rtl/sram_arbiter_pkg.sv | 15 +
 rtl/sram_arbiter_seq.sv | 99 +++++++++
 rtl/sram_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: access-sequencer states and owner codes.
package sram_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StDone   = 2'd2
   } seq_state_e;

   typedef enum logic {
      OwnVga = 1'b0,
      OwnCpu = 1'b1
   } owner_e;

endpackage

// File: rtl/sram_arbiter_seq.sv
// SRAM access sequencer: latches one granted access, drives the SRAM pins for
// WaitCycles+1 cycles, captures read data and flags completion for one cycle.
module sram_arbiter_seq
   import sram_arbiter_pkg::*;
#(
   parameter int unsigned AddrW      = 19,
   parameter int unsigned WaitCycles = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  owner_e           owner_i,
   input  logic [AddrW-1:0] addr_i,
   input  logic             we_i,
   input  logic [31:0]      wdata_i,
   input  logic [31:0]      mem_din_i,
   output logic             idle_o,
   output logic             done_o,
   output owner_e           owner_o,
   output logic [31:0]      rdata_o,
   output logic [AddrW-1:0] mem_addr_o,
   output logic [31:0]      mem_dout_o,
   output logic             mem_ce_n_o,
   output logic             mem_oe_n_o,
   output logic             mem_we_n_o
);

   localparam int unsigned CntW = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;

   seq_state_e       state_q;
   owner_e           owner_q;
   logic [CntW-1:0]  cnt_q;
   logic             we_q;
   logic             done_q;
   logic [31:0]      rdata_q;
   logic [AddrW-1:0] mem_addr_q;
   logic [31:0]      mem_dout_q;
   logic             ce_n_q, oe_n_q, we_n_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         owner_q    <= OwnVga;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         done_q     <= 1'b0;
         rdata_q    <= '0;
         mem_addr_q <= '0;
         mem_dout_q <= '0;
         ce_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         we_n_q     <= 1'b1;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  state_q    <= StAccess;
                  owner_q    <= owner_i;
                  we_q       <= we_i;
                  mem_addr_q <= addr_i;
                  mem_dout_q <= wdata_i;
                  cnt_q      <= CntW'(WaitCycles);
                  ce_n_q     <= 1'b0;
                  oe_n_q     <= we_i;
                  // Write strobe never asserts in the final ACCESS cycle (data hold).
                  we_n_q     <= !(we_i && (WaitCycles != 0));
               end
            end
            StAccess: begin
               if (cnt_q == '0) begin
                  if (!we_q) rdata_q <= mem_din_i;
                  ce_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  we_n_q  <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == CntW'(1)) we_n_q <= 1'b1;
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign idle_o     = (state_q == StIdle);
   assign done_o     = done_q;
   assign owner_o    = owner_q;
   assign rdata_o    = rdata_q;
   assign mem_addr_o = mem_addr_q;
   assign mem_dout_o = mem_dout_q;
   assign mem_ce_n_o = ce_n_q;
   assign mem_oe_n_o = oe_n_q;
   assign mem_we_n_o = we_n_q;

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM between the VGA fetcher (priority) and the CPU; a VGA streak
// limit guarantees CPU progress while both are requesting.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W        = 19,
   parameter int unsigned WAIT_CYCLES   = 2,
   parameter int unsigned VGA_BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vga_read_i,
   input  logic [31:0]       vga_addr_i,
   output logic [31:0]       vga_data_o,
   output logic              vga_rdy_o,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_wdata_i,
   output logic [31:0]       cpu_rdata_o,
   output logic              cpu_ack_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_dout_o,
   input  logic [31:0]       mem_din_i,
   output logic              mem_ce_n_o,
   output logic              mem_oe_n_o,
   output logic              mem_we_n_o
);

   localparam int unsigned StreakW = $clog2(VGA_BURST_MAX + 1);
   localparam logic [StreakW-1:0] StreakMax = StreakW'(VGA_BURST_MAX);

   logic [StreakW-1:0] streak_q, streak_d;
   logic               idle, done, start, grant_vga, grant_cpu;
   owner_e             owner_sel, owner_done;
   logic [ADDR_W-1:0]  addr_sel;
   logic [31:0]        rdata;
   logic               unused_addr_bits;

   assign unused_addr_bits = ^{vga_addr_i[1:0], vga_addr_i[31:ADDR_W+2],
                               cpu_addr_i[1:0], cpu_addr_i[31:ADDR_W+2]};

   always_comb begin
      grant_vga = vga_read_i && (!cpu_req_i || (streak_q != StreakMax));
      grant_cpu = cpu_req_i && !grant_vga;
      start     = idle && (grant_vga || grant_cpu);
      owner_sel = grant_vga ? OwnVga : OwnCpu;
      addr_sel  = grant_vga ? vga_addr_i[ADDR_W+1:2] : cpu_addr_i[ADDR_W+1:2];
      streak_d  = streak_q;
      if (idle) begin
         if (!cpu_req_i || grant_cpu) begin
            streak_d = '0;
         end else if (grant_vga && (streak_q != StreakMax)) begin
            streak_d = streak_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) streak_q <= '0;
      else        streak_q <= streak_d;
   end

   sram_arbiter_seq #(
      .AddrW      (ADDR_W),
      .WaitCycles (WAIT_CYCLES)
   ) u_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start),
      .owner_i    (owner_sel),
      .addr_i     (addr_sel),
      .we_i       (grant_cpu && cpu_we_i),
      .wdata_i    (cpu_wdata_i),
      .mem_din_i  (mem_din_i),
      .idle_o     (idle),
      .done_o     (done),
      .owner_o    (owner_done),
      .rdata_o    (rdata),
      .mem_addr_o (mem_addr_o),
      .mem_dout_o (mem_dout_o),
      .mem_ce_n_o (mem_ce_n_o),
      .mem_oe_n_o (mem_oe_n_o),
      .mem_we_n_o (mem_we_n_o)
   );

   assign vga_rdy_o   = done && (owner_done == OwnVga);
   assign cpu_ack_o   = done && (owner_done == OwnCpu);
   assign vga_data_o  = rdata;
   assign cpu_rdata_o = rdata;

endmodule
